bas_restart_ctrl: RTL and testbench
===================================

Name: bas_restart_ctrl

Overview:
- Multi-start sequencer directly upstream and downstream of the `bas` optimiser core.
- Drives bas reset/load, seeds, start point and iteration budget for NUM_RUNS consecutive runs.
- Waits for bas done on each run, then captures x_extreme, y_extreme and out_value.
- Keeps a global best (lowest signed value) across runs and presents it to the host with a valid flag.

Parameters:
- NUM_RUNS, 8: runs per start command (1..256).
- SEED_STEP, 9'd37: added to both seeds between runs, mod 512.
- X_STEP, 16'sh0100: start-x increment per run (Q8.8).
- Y_STEP, 16'sh0080: start-y increment per run (Q8.8).
- TIMEOUT_MARGIN, 32: cycles beyond iterations before a run is declared hung.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  begin sequence; sampled in IDLE only
- iterations_in  in  9  per-run iteration budget; latched on start
- seed_x_init  in  9  first x seed; latched on start
- seed_y_init  in  9  first y seed; latched on start
- x_base  in  16  first start x, signed Q8.8; latched on start
- y_base  in  16  first start y, signed Q8.8; latched on start
- bas_reset  out  1  to bas reset
- bas_load  out  1  to bas load
- bas_seed_x  out  9  to bas seed_x
- bas_seed_y  out  9  to bas seed_y
- bas_iterations  out  9  to bas iterations
- bas_x  out  16  to bas x
- bas_y  out  16  to bas y
- bas_done  in  1  from bas
- bas_x_extreme  in  16  from bas, signed
- bas_y_extreme  in  16  from bas, signed
- bas_out_value  in  40  from bas, signed
- busy  out  1  sequence in progress
- result_valid  out  1  sequence finished; best_* stable
- best_found  out  1  at least one run completed without timeout
- best_x  out  16  global best x
- best_y  out  16  global best y
- best_value  out  40  global best value
- best_run  out  8  index of the run that produced the best
- timeout_err  out  1  sticky; at least one run hung

Behaviour:
- Interface: reset is synchronous, active-high; clock is `clock`.
- Reset values:
  - busy, result_valid, best_found, timeout_err, best_run = 0.
  - best_x, best_y = 0; best_value = 40'sh7F_FFFF_FFFF.
  - State = IDLE.
- bas_reset is combinational: `reset | (state==RST)`. A controller reset therefore also resets bas in the same cycle.
- FSM states and transitions:
  - IDLE: on start, latch inputs, run_idx=0, clear result_valid/best_*/timeout_err, go to RST. busy=1 from the next cycle.
  - RST (1 cycle): bas_reset=1. Seeds and start point are driven and stable; bas latches x/y here.
  - LOAD (1 cycle): bas_load=1; all outputs to bas are held stable; clear watchdog.
  - RUN: wait for bas_done=1 and go to CAPTURE. If the watchdog reaches iterations+TIMEOUT_MARGIN, set timeout_err and go to NEXT without capture.
  - CAPTURE (1 cycle): if bas_out_value < best_value (signed, strict), update best_x, best_y, best_value, best_run=run_idx and set best_found. Ties keep the earlier run.
  - NEXT: if run_idx==NUM_RUNS-1, go to DONE. Otherwise run_idx++, step the seeds and start point, and go to RST.
  - DONE: busy=0, result_valid=1, go to IDLE. result_valid stays high until the next accepted start.
- Seed step: seed = (seed + SEED_STEP) mod 512; a result of 0 is replaced by 9'h001 (an all-zero seed locks the LFSR).
- Start-point step: x += X_STEP, y += Y_STEP, 16-bit two's-complement wrap, no saturation.
- start in any state other than IDLE is ignored.
- iterations_in=0 is legal: bas asserts done right after load.
- Per-run overhead is 4 controller cycles (RST, LOAD, CAPTURE, NEXT) plus the bas run time.
- Reset mid-operation: bas is reset in the same cycle; all outputs return to reset values on the next edge.

Optional Feature:
- Macro: BAS_RUN_TRACE_EN.
- Defined: adds ports run_valid (1-cycle pulse in CAPTURE, or in NEXT on timeout), run_idx_o[7:0], run_value[39:0], run_x[15:0], run_y[15:0] and run_timeout. Every run is streamed out for logging.
- Undefined: these ports do not exist and the logic is removed.

Decomposition:
- Package bas_pkg holds:
  - COORD_W=16, VAL_W=40, SEED_W=9, ITER_W=9.
  - VALUE_MAX=40'sh7F_FFFF_FFFF.
  - The FSM state enum {IDLE, RST, LOAD, RUN, CAPTURE, NEXT, DONE}.
- One natural sub-module, bas_best_tracker: a signed comparator plus the best_* registers, with clear and update inputs.

Test Plan:
- NUM_RUNS=4, bas stub returns values 500, 300, 300, 700 -> best_value=300, best_run=1, result_valid=1, busy=0.
- seed_x_init=9'h1DB, SEED_STEP=37 -> run1 bas_seed_x=9'h001 (sum is 0, replaced), run2 bas_seed_x=9'h026.
- iterations_in=10, TIMEOUT_MARGIN=32, stub never asserts done -> each run leaves RUN after 42 cycles; timeout_err=1, best_found=0, best_value=VALUE_MAX.
- Stub values -5 then 3 -> best_value=-5, best_run=0 (signed comparison).
- reset asserted in RUN of run 2 -> bas_reset=1 in the same cycle; next cycle busy=0, result_valid=0, best_value=VALUE_MAX.
- start re-pulsed while busy -> ignored, sequence completes normally; after DONE, result_valid holds until the next start, which clears it.

Source files
------------

// File: rtl/bas_pkg.sv
// Shared widths, limits, FSM encoding and seed stepping for the bas restart controller.
package bas_pkg;

  localparam int COORD_W = 16;
  localparam int VAL_W   = 40;
  localparam int SEED_W  = 9;
  localparam int ITER_W  = 9;

  localparam logic signed [VAL_W-1:0] VALUE_MAX = 40'sh7F_FFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    LOAD,
    RUN,
    CAPTURE,
    NEXT,
    DONE
  } state_t;

  // Advance a seed with modulo-512 wrap; zero would lock the bas LFSR, so it becomes 1.
  function automatic logic [SEED_W-1:0] seed_step(input logic [SEED_W-1:0] seed,
                                                  input logic [SEED_W-1:0] step);
    logic [SEED_W-1:0] sum;
    sum = seed + step;
    return (sum == '0) ? {{(SEED_W-1){1'b0}}, 1'b1} : sum;
  endfunction

endpackage

// File: rtl/bas_restart_ctrl_if.sv
// Signals between the restart controller (master) and the bas optimiser core (slave).
interface bas_restart_ctrl_if;
  import bas_pkg::*;

  logic                      bas_reset;
  logic                      bas_load;
  logic [SEED_W-1:0]         bas_seed_x;
  logic [SEED_W-1:0]         bas_seed_y;
  logic [ITER_W-1:0]         bas_iterations;
  logic signed [COORD_W-1:0] bas_x;
  logic signed [COORD_W-1:0] bas_y;
  logic                      bas_done;
  logic signed [COORD_W-1:0] bas_x_extreme;
  logic signed [COORD_W-1:0] bas_y_extreme;
  logic signed [VAL_W-1:0]   bas_out_value;

  modport master (
    output bas_reset, bas_load, bas_seed_x, bas_seed_y, bas_iterations, bas_x, bas_y,
    input  bas_done, bas_x_extreme, bas_y_extreme, bas_out_value
  );

  modport slave (
    input  bas_reset, bas_load, bas_seed_x, bas_seed_y, bas_iterations, bas_x, bas_y,
    output bas_done, bas_x_extreme, bas_y_extreme, bas_out_value
  );

endinterface

// File: rtl/bas_best_tracker.sv
// Holds the lowest signed value seen across runs together with its coordinates and run index.
// A strict less-than compare keeps the earliest run on ties.
module bas_best_tracker
  import bas_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      update,
  input  logic signed [VAL_W-1:0]   cand_value,
  input  logic signed [COORD_W-1:0] cand_x,
  input  logic signed [COORD_W-1:0] cand_y,
  input  logic [7:0]                cand_run,
  output logic                      best_found,
  output logic signed [COORD_W-1:0] best_x,
  output logic signed [COORD_W-1:0] best_y,
  output logic signed [VAL_W-1:0]   best_value,
  output logic [7:0]                best_run
);

  logic                      best_found_q, best_found_d;
  logic signed [COORD_W-1:0] best_x_q, best_x_d;
  logic signed [COORD_W-1:0] best_y_q, best_y_d;
  logic signed [VAL_W-1:0]   best_value_q, best_value_d;
  logic [7:0]                best_run_q, best_run_d;
  logic                      better;

  assign better = (cand_value < best_value_q);

  // Next best: clear on a new sequence, otherwise take a strictly better candidate.
  always_comb begin
    best_found_d = best_found_q;
    best_x_d     = best_x_q;
    best_y_d     = best_y_q;
    best_value_d = best_value_q;
    best_run_d   = best_run_q;
    if (clear) begin
      best_found_d = 1'b0;
      best_x_d     = '0;
      best_y_d     = '0;
      best_value_d = VALUE_MAX;
      best_run_d   = '0;
    end else if (update && better) begin
      best_found_d = 1'b1;
      best_x_d     = cand_x;
      best_y_d     = cand_y;
      best_value_d = cand_value;
      best_run_d   = cand_run;
    end
  end

  // Best-so-far registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      best_found_q <= 1'b0;
      best_x_q     <= '0;
      best_y_q     <= '0;
      best_value_q <= VALUE_MAX;
      best_run_q   <= '0;
    end else begin
      best_found_q <= best_found_d;
      best_x_q     <= best_x_d;
      best_y_q     <= best_y_d;
      best_value_q <= best_value_d;
      best_run_q   <= best_run_d;
    end
  end

  assign best_found = best_found_q;
  assign best_x     = best_x_q;
  assign best_y     = best_y_q;
  assign best_value = best_value_q;
  assign best_run   = best_run_q;

endmodule

// File: rtl/bas_restart_ctrl.sv
// Multi-start sequencer around the bas optimiser: runs bas NUM_RUNS times with stepped
// seeds and start points, guards each run with a watchdog, and keeps the global best.
// Optional macro BAS_RUN_TRACE_EN adds a per-run trace stream (run_valid, run_idx_o,
// run_value, run_x, run_y, run_timeout).
//
// state   | meaning
// IDLE    | waiting for start; result_valid holds the last outcome
// RST     | bas held in reset, seeds and start point presented
// LOAD    | bas_load pulse, watchdog cleared
// RUN     | waiting for bas_done or watchdog expiry
// CAPTURE | offer bas result to the best tracker
// NEXT    | last run -> DONE, else step seeds/start point -> RST
// DONE    | sequence finished, result_valid raised
module bas_restart_ctrl
  import bas_pkg::*;
#(
  parameter int                        NUM_RUNS       = 8,
  parameter logic [SEED_W-1:0]         SEED_STEP      = 9'd37,
  parameter logic signed [COORD_W-1:0] X_STEP         = 16'sh0100,
  parameter logic signed [COORD_W-1:0] Y_STEP         = 16'sh0080,
  parameter int                        TIMEOUT_MARGIN = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ITER_W-1:0]         iterations_in,
  input  logic [SEED_W-1:0]         seed_x_init,
  input  logic [SEED_W-1:0]         seed_y_init,
  input  logic signed [COORD_W-1:0] x_base,
  input  logic signed [COORD_W-1:0] y_base,
  bas_restart_ctrl_if.master        bas,
  output logic                      busy,
  output logic                      result_valid,
  output logic                      best_found,
  output logic signed [COORD_W-1:0] best_x,
  output logic signed [COORD_W-1:0] best_y,
  output logic signed [VAL_W-1:0]   best_value,
  output logic [7:0]                best_run,
  output logic                      timeout_err
`ifdef BAS_RUN_TRACE_EN
  ,
  output logic                      run_valid,
  output logic [7:0]                run_idx_o,
  output logic signed [VAL_W-1:0]   run_value,
  output logic signed [COORD_W-1:0] run_x,
  output logic signed [COORD_W-1:0] run_y,
  output logic                      run_timeout
`endif
);

  // Watchdog wide enough for the largest budget plus margin.
  localparam int         WD_W     = $clog2((1 << ITER_W) + TIMEOUT_MARGIN);
  localparam logic [7:0] LAST_RUN = 8'(NUM_RUNS - 1);

  state_t                    state_q, state_d;
  logic [7:0]                run_idx_q, run_idx_d;
  logic [ITER_W-1:0]         iter_q, iter_d;
  logic [SEED_W-1:0]         seed_x_q, seed_x_d;
  logic [SEED_W-1:0]         seed_y_q, seed_y_d;
  logic signed [COORD_W-1:0] x_q, x_d;
  logic signed [COORD_W-1:0] y_q, y_d;
  logic [WD_W-1:0]           wdog_q, wdog_d;
  logic                      busy_q, busy_d;
  logic                      result_valid_q, result_valid_d;
  logic                      timeout_err_q, timeout_err_d;

  logic [WD_W-1:0] wdog_inc;
  logic [WD_W-1:0] wd_limit;
  logic            wd_expired;
  logic            trk_clear;
  logic            trk_update;

  assign wdog_inc   = wdog_q + 1'b1;
  assign wd_limit   = WD_W'(iter_q) + WD_W'(TIMEOUT_MARGIN);
  assign wd_expired = (wdog_inc == wd_limit);
  assign trk_clear  = (state_q == IDLE) && start;
  assign trk_update = (state_q == CAPTURE);

  // Sequencer next-state and datapath updates.
  always_comb begin
    state_d        = state_q;
    run_idx_d      = run_idx_q;
    iter_d         = iter_q;
    seed_x_d       = seed_x_q;
    seed_y_d       = seed_y_q;
    x_d            = x_q;
    y_d            = y_q;
    wdog_d         = wdog_q;
    busy_d         = busy_q;
    result_valid_d = result_valid_q;
    timeout_err_d  = timeout_err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          iter_d         = iterations_in;
          seed_x_d       = seed_x_init;
          seed_y_d       = seed_y_init;
          x_d            = x_base;
          y_d            = y_base;
          run_idx_d      = '0;
          result_valid_d = 1'b0;
          timeout_err_d  = 1'b0;
          busy_d         = 1'b1;
          state_d        = RST;
        end
      end
      RST: state_d = LOAD;
      LOAD: begin
        wdog_d  = '0;
        state_d = RUN;
      end
      RUN: begin
        if (bas.bas_done) begin
          state_d = CAPTURE;
        end else if (wd_expired) begin
          timeout_err_d = 1'b1;
          state_d       = NEXT;
        end else begin
          wdog_d = wdog_inc;
        end
      end
      CAPTURE: state_d = NEXT;
      NEXT: begin
        if (run_idx_q == LAST_RUN) begin
          busy_d         = 1'b0;
          result_valid_d = 1'b1;
          state_d        = DONE;
        end else begin
          run_idx_d = run_idx_q + 8'd1;
          seed_x_d  = seed_step(seed_x_q, SEED_STEP);
          seed_y_d  = seed_step(seed_y_q, SEED_STEP);
          x_d       = x_q + X_STEP;
          y_d       = y_q + Y_STEP;
          state_d   = RST;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      run_idx_q      <= '0;
      iter_q         <= '0;
      seed_x_q       <= '0;
      seed_y_q       <= '0;
      x_q            <= '0;
      y_q            <= '0;
      wdog_q         <= '0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      run_idx_q      <= run_idx_d;
      iter_q         <= iter_d;
      seed_x_q       <= seed_x_d;
      seed_y_q       <= seed_y_d;
      x_q            <= x_d;
      y_q            <= y_d;
      wdog_q         <= wdog_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  // bas reset follows the controller reset in the same cycle.
  assign bas.bas_reset      = reset | (state_q == RST);
  assign bas.bas_load       = (state_q == LOAD);
  assign bas.bas_seed_x     = seed_x_q;
  assign bas.bas_seed_y     = seed_y_q;
  assign bas.bas_iterations = iter_q;
  assign bas.bas_x          = x_q;
  assign bas.bas_y          = y_q;

  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign timeout_err  = timeout_err_q;

  bas_best_tracker u_best (
    .clock      (clock),
    .reset      (reset),
    .clear      (trk_clear),
    .update     (trk_update),
    .cand_value (bas.bas_out_value),
    .cand_x     (bas.bas_x_extreme),
    .cand_y     (bas.bas_y_extreme),
    .cand_run   (run_idx_q),
    .best_found (best_found),
    .best_x     (best_x),
    .best_y     (best_y),
    .best_value (best_value),
    .best_run   (best_run)
  );

`ifdef BAS_RUN_TRACE_EN
  logic run_to_q, run_to_d;

  // Remember whether the current run ended by watchdog so NEXT can report it.
  always_comb begin
    run_to_d = run_to_q;
    if (state_q == LOAD) begin
      run_to_d = 1'b0;
    end else if ((state_q == RUN) && !bas.bas_done && wd_expired) begin
      run_to_d = 1'b1;
    end
  end

  // Timeout flag register.
  always_ff @(posedge clock) begin
    if (reset) begin
      run_to_q <= 1'b0;
    end else begin
      run_to_q <= run_to_d;
    end
  end

  assign run_valid   = (state_q == CAPTURE) | ((state_q == NEXT) & run_to_q);
  assign run_timeout = (state_q == NEXT) & run_to_q;
  assign run_idx_o   = run_idx_q;
  assign run_value   = bas.bas_out_value;
  assign run_x       = bas.bas_x_extreme;
  assign run_y       = bas.bas_y_extreme;
`endif

endmodule

// File: tb/tb_bas_restart_ctrl.sv
// Bench for bas_restart_ctrl with a behavioural bas stub and a reference model.
module tb_bas_restart_ctrl;
  import bas_pkg::*;

  localparam int     NR     = 4;
  localparam int     MARGIN = 32;
  localparam longint VMAX   = 64'sd549755813887;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [8:0]        iterations_in = '0;
  logic [8:0]        seed_x_init = '0;
  logic [8:0]        seed_y_init = '0;
  logic signed [15:0] x_base = '0;
  logic signed [15:0] y_base = '0;
  logic              busy, result_valid, best_found, timeout_err;
  logic signed [15:0] best_x, best_y;
  logic signed [39:0] best_value;
  logic [7:0]        best_run;

  int tests = 0;
  int fails = 0;

  bas_restart_ctrl_if bif ();

  bas_restart_ctrl #(.NUM_RUNS(NR), .TIMEOUT_MARGIN(MARGIN)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .iterations_in (iterations_in),
    .seed_x_init   (seed_x_init),
    .seed_y_init   (seed_y_init),
    .x_base        (x_base),
    .y_base        (y_base),
    .bas           (bif),
    .busy          (busy),
    .result_valid  (result_valid),
    .best_found    (best_found),
    .best_x        (best_x),
    .best_y        (best_y),
    .best_value    (best_value),
    .best_run      (best_run),
    .timeout_err   (timeout_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  // bas stub state
  longint             stub_vals [NR];
  logic signed [15:0] stub_xe [NR];
  logic signed [15:0] stub_ye [NR];
  int                 stub_delay = 0;
  bit                 stub_hang = 0;
  int                 load_cnt = 0;
  int                 cnt = 0;
  bit                 armed = 0;
  bit                 rst_prev = 1'b1;
  logic [8:0]         rec_sx [$];
  logic [8:0]         rec_sy [$];
  logic [8:0]         rec_it [$];
  logic [15:0]        rec_x [$];
  logic [15:0]        rec_y [$];
  int                 load_cyc [$];
  int                 rst_cyc [$];

  // Behavioural bas: done some cycles after load, results fixed per run index.
  always @(negedge clock) begin
    int k;
    longint v;
    if (bif.bas_reset) begin
      bif.bas_done = 1'b0;
      armed = 1'b0;
      if (!rst_prev) rst_cyc.push_back(cyc);
    end else if (bif.bas_load) begin
      rec_sx.push_back(bif.bas_seed_x);
      rec_sy.push_back(bif.bas_seed_y);
      rec_it.push_back(bif.bas_iterations);
      rec_x.push_back(bif.bas_x);
      rec_y.push_back(bif.bas_y);
      load_cyc.push_back(cyc);
      k = load_cnt % NR;
      load_cnt++;
      v = stub_vals[k];
      bif.bas_out_value = v[39:0];
      bif.bas_x_extreme = stub_xe[k];
      bif.bas_y_extreme = stub_ye[k];
      bif.bas_done = 1'b0;
      armed = 1'b1;
      cnt = stub_delay;
    end else if (armed && !stub_hang) begin
      if (cnt == 0) bif.bas_done = 1'b1;
      else cnt--;
    end
    rst_prev = bif.bas_reset;
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int nseed(input int s);
    int r;
    r = (s + 37) % 512;
    if (r == 0) r = 1;
    return r;
  endfunction

  // Runs one full sequence and checks per-run bas inputs and the final best against the model.
  task automatic run_seq(input logic [8:0] it, input logic [8:0] sx, input logic [8:0] sy,
                         input logic [15:0] xb, input logic [15:0] yb, input bit pulse_mid);
    int n;
    int s_x, s_y;
    longint best, bx, by;
    int brun;
    bit found;
    logic [15:0] xk, yk;
    rec_sx.delete(); rec_sy.delete(); rec_it.delete(); rec_x.delete(); rec_y.delete();
    load_cyc.delete(); rst_cyc.delete();
    load_cnt = 0;
    @(negedge clock);
    iterations_in = it; seed_x_init = sx; seed_y_init = sy; x_base = xb; y_base = yb;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (!result_valid && n < 3000) begin
      @(negedge clock);
      n++;
      if (pulse_mid && n == 8) begin
        start = 1'b1; iterations_in = ~it; seed_x_init = ~sx; x_base = ~xb;
      end
      if (pulse_mid && n == 9) begin
        start = 1'b0; iterations_in = it; seed_x_init = sx; x_base = xb;
      end
    end
    check("seq_complete", longint'(n < 3000), 1);
    check("busy_at_done", busy, 0);
    check("load_count", rec_sx.size(), NR);
    s_x = sx; s_y = sy;
    best = VMAX; brun = 0; found = 0; bx = 0; by = 0;
    for (int k = 0; k < NR; k++) begin
      xk = 16'(int'(xb) + k * 256);
      yk = 16'(int'(yb) + k * 128);
      if (k < rec_sx.size()) begin
        check($sformatf("seed_x_run%0d", k), rec_sx[k], s_x);
        check($sformatf("seed_y_run%0d", k), rec_sy[k], s_y);
        check($sformatf("iter_run%0d", k), rec_it[k], it);
        check($sformatf("x_run%0d", k), rec_x[k], xk);
        check($sformatf("y_run%0d", k), rec_y[k], yk);
      end
      s_x = nseed(s_x); s_y = nseed(s_y);
      if (!stub_hang && stub_vals[k] < best) begin
        best = stub_vals[k]; brun = k; found = 1;
        bx = stub_xe[k]; by = stub_ye[k];
      end
    end
    check("best_value", best_value, best);
    check("best_run", best_run, brun);
    check("best_found", best_found, found);
    check("best_x", best_x, bx);
    check("best_y", best_y, by);
    check("timeout_err", timeout_err, stub_hang);
  endtask

  typedef struct {
    longint v0, v1, v2, v3;
    int     dly;
    longint exp_val;
    int     exp_run;
    bit     exp_found;
  } vec_t;

  initial begin
    vec_t tbl [5];
    int n;
    logic [39:0] r40;
    logic signed [39:0] s40;

    tbl[0] = '{500, 300, 300, 700, 2, 300, 1, 1};
    tbl[1] = '{-5, 3, 10, 20, 0, -5, 0, 1};
    tbl[2] = '{7, 7, 7, 7, 3, 7, 0, 1};
    tbl[3] = '{VMAX, VMAX, VMAX, VMAX, 1, VMAX, 0, 0};
    tbl[4] = '{100, 50, -64'sd549755813888, 0, 1, -64'sd549755813888, 2, 1};

    // reset values
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_best_found", best_found, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_best_run", best_run, 0);
    check("rst_best_x", best_x, 0);
    check("rst_best_y", best_y, 0);
    check("rst_best_value", best_value, VMAX);
    check("rst_bas_reset", bif.bas_reset, 1);
    check("rst_bas_load", bif.bas_load, 0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_bas_reset", bif.bas_reset, 0);

    // table vectors
    for (int i = 0; i < 5; i++) begin
      stub_vals[0] = tbl[i].v0; stub_vals[1] = tbl[i].v1;
      stub_vals[2] = tbl[i].v2; stub_vals[3] = tbl[i].v3;
      stub_delay = tbl[i].dly;
      stub_hang = 1'b0;
      for (int k = 0; k < NR; k++) begin
        stub_xe[k] = 16'(k * 300 - 400 + i);
        stub_ye[k] = 16'(777 - k * 55 - i);
      end
      run_seq(9'd5, (i == 0) ? 9'h1DB : 9'(i * 61), 9'(i * 13 + 2), 16'h7F80, 16'(i * 1000), 1'b0);
      check($sformatf("tbl%0d_value", i), best_value, tbl[i].exp_val);
      check($sformatf("tbl%0d_run", i), best_run, tbl[i].exp_run);
      check($sformatf("tbl%0d_found", i), best_found, tbl[i].exp_found);
      check($sformatf("tbl%0d_valid", i), result_valid, 1);
      if (i == 0) begin
        check("seed_wrap_run1", rec_sx[1], 9'h001);
        check("seed_run2", rec_sx[2], 9'h026);
      end
    end

    // randomized sequences against the model
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < NR; k++) begin
        if (i % 2 == 0) begin
          stub_vals[k] = longint'($urandom_range(0, 20)) - 10;
        end else begin
          r40 = {$urandom(), $urandom()};
          s40 = r40;
          stub_vals[k] = s40;
        end
        stub_xe[k] = 16'($urandom());
        stub_ye[k] = 16'($urandom());
      end
      stub_delay = $urandom_range(0, 6);
      stub_hang = 1'b0;
      run_seq((i == 0) ? 9'd0 : 9'($urandom()), 9'($urandom()), 9'($urandom()),
              16'($urandom()), 16'($urandom()), 1'b0);
    end

    // watchdog: bas never finishes
    stub_hang = 1'b1;
    run_seq(9'd10, 9'd3, 9'd4, 16'h0000, 16'h0000, 1'b0);
    check("to_best_value", best_value, VMAX);
    check("to_best_found", best_found, 0);
    for (int k = 0; k < NR - 1; k++) begin
      if (k + 1 < rst_cyc.size() && k < load_cyc.size())
        check($sformatf("to_run%0d_len", k), rst_cyc[k + 1] - load_cyc[k], 10 + MARGIN + 2);
      else
        check($sformatf("to_run%0d_seen", k), 0, 1);
    end
    stub_hang = 1'b0;

    // start re-pulsed while busy is ignored
    stub_vals[0] = 40; stub_vals[1] = -12; stub_vals[2] = 90; stub_vals[3] = -12;
    stub_delay = 1;
    run_seq(9'd20, 9'd100, 9'd200, 16'hFF00, 16'h0040, 1'b1);
    repeat (5) @(negedge clock);
    check("valid_holds", result_valid, 1);
    check("valid_holds_run", best_run, 1);

    // next start clears result_valid, then reset lands in RUN of run 2
    stub_delay = 50;
    iterations_in = 9'd100;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("restart_clears_valid", result_valid, 0);
    check("restart_busy", busy, 1);
    n = 0;
    begin
      int loads;
      loads = 0;
      while (loads < 3 && n < 1000) begin
        @(posedge clock);
        #1;
        if (bif.bas_load) loads++;
        n++;
      end
    end
    check("reach_run2", longint'(n < 1000), 1);
    @(posedge clock);
    #1;
    check("pre_reset_best", longint'(best_value != 40'sh7F_FFFF_FFFF), 1);
    reset = 1'b1;
    #1;
    check("mid_reset_bas_reset", bif.bas_reset, 1);
    @(posedge clock);
    #1;
    check("mid_reset_busy", busy, 0);
    check("mid_reset_valid", result_valid, 0);
    check("mid_reset_value", best_value, VMAX);
    check("mid_reset_found", best_found, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("post_reset_bas_reset", bif.bas_reset, 0);
    check("post_reset_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
